quad_down_counter: RTL
======================

Name: quad_down_counter

Overview:
- Cascaded base-4 down counter. Each digit is 2 bits, and digits are chained through a 2-bit subtract-with-borrow cell, so it is the subtracting counterpart of the counter lab's 2-bit adder cell.
- Loadable, with an enable, one-shot or periodic reload, and a registered expiry pulse.
- Sits in the counter lab as the countdown/timer element. It pairs with the up-counting adder chain: same digit format, opposite direction.

Parameters:
- DIGITS, 4, number of base-4 digits; counter width W = 2*DIGITS (default 8 bits, range 0..255).
- PERIODIC, 0, 0 = one-shot (stop at expiry), 1 = reload the captured value on expiry and keep running.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- load  input  1  capture load_val into count and the reload register
- load_val  input  W  value to load; digit k = load_val[2k+1:2k]
- en  input  1  count-down enable, sampled each rising edge
- count  output  W  current count, registered
- zero  output  1  combinational, high when count == 0
- expire  output  1  registered one-cycle pulse on expiry
- busy  output  1  high in state RUN

Behaviour:
- Reset (reset==0, asynchronous, any time, including mid-count):
  - count=0, reload register=0, state=IDLE, expire=0, busy=0, zero=1.
  - Release is sampled synchronously; the first active edge after release sees the IDLE state.
- States: IDLE, RUN, EXPIRED. All transitions occur on the rising clk edge.
- load has highest priority in every state:
  - count<=load_val, reload<=load_val, state<=RUN, expire<=0.
  - en in the same cycle is ignored; no decrement on the load edge.
- IDLE: en ignored, count held. Only load leaves this state.
- RUN, en=1, count!=0:
  - count<=count-1 through the digit chain. Digit 0 has borrow-in 1; digit k has borrow-in equal to digit k-1's borrow-out.
  - Each digit computes d-bin mod 4, with bout=1 iff d<bin.
  - Example: 0x40 (digits 1,0,0,0) -> 0x3F (digits 0,3,3,3).
- RUN, en=1, count==0 (expiry):
  - expire<=1 for exactly one cycle.
  - PERIODIC=0: state<=EXPIRED, count stays 0.
  - PERIODIC=1: count<=reload, state stays RUN.
  - Expiry therefore occurs on the (N+1)th enabled edge after loading N, i.e. the period is N+1 enabled cycles.
- RUN, en=0: count held, expire<=0.
- EXPIRED: en ignored, count held at 0, busy=0. Only load or reset exit.
- load_val==0 case:
  - Enters RUN.
  - The first enabled edge expires.
  - With PERIODIC=1, the counter expires on every enabled edge.
- expire is deasserted on every edge that is not an expiry edge. It can never be high for two consecutive cycles unless consecutive expiries occur (PERIODIC=1 with reload==0).
- Wrap-around below zero never occurs; the zero state is always handled as expiry.
- The top digit's borrow-out is unused except inside the expiry detect.
- Arithmetic is unsigned, modulo 4 per digit, with no carry beyond digit DIGITS-1.

Decomposition:
- Shared package for the counter lab:
  - DIGIT_W=2 constant.
  - State encoding constants IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10.
  - The 2-bit adder cell uses the same DIGIT_W.
- One sub-module: digit_sub, the 2-bit subtract-with-borrow cell.
  - Ports: d[1:0], bin → q[1:0], bout.
  - Pure gate-level, mirroring the adder cell's style.
  - Instantiated DIGITS times in a generate chain.
- The top level holds the state register, count register, reload register and expire register.

Test Plan:
- Reset behaviour: pulse reset low mid-count (count=0x25) → count=0, expire=0, busy=0, zero=1 immediately, without waiting for a clock edge. en=1 after release with no load → count stays 0, no expire.
- One-shot countdown: PERIODIC=0, load 0x03, en=1 continuously →
  - count 3,2,1,0 on successive edges;
  - expire=1 on the 4th enabled edge, for one cycle only;
  - busy falls; count held at 0 for 10 further enabled cycles.
- Borrow ripple: load 0x40, single enabled edge → count=0x3F. Then load 0x100-equivalent max 0xFF and run 255 enabled edges → count=0x00 with no expire yet; the next enabled edge gives expire=1.
- Periodic mode: PERIODIC=1, load 0x02, en=1 for 9 cycles →
  - sequence 2,1,0,2,1,0,2,1,0;
  - expire high on edges 3, 6 and 9 only;
  - busy stays 1 throughout.
- Enable gating: load 0x05, en pattern 1,0,0,1 → count 4,4,4,3, expire never asserted.
- Load priority: mid-count (count=0x10), assert load=1 with load_val=0x07 and en=1 on the same edge → count=0x07 exactly. Load 0x00 then one enabled edge → expire=1.

Source files
------------

// File: rtl/quad_down_counter_pkg.sv
// Shared counter-lab definitions: digit width and countdown FSM encoding.
// Used by the subtract cell, the adder cell and the down counter top.
package quad_down_counter_pkg;

    localparam int DIGIT_W = 2;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } state_t;

endpackage

// File: rtl/quad_down_counter_if.sv
// Control/status bundle between the down counter and whoever drives it.
// The master loads and enables; the slave reports count and expiry status.
interface quad_down_counter_if #(
    parameter int W = 8
);

    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] count;
    logic         zero;
    logic         expire;
    logic         busy;

    modport master (
        output load, load_val, en,
        input  count, zero, expire, busy
    );

    modport slave (
        input  load, load_val, en,
        output count, zero, expire, busy
    );

endinterface

// File: rtl/quad_down_counter_digit_sub.sv
// Base-4 subtract-with-borrow cell: q = (d - bin) mod 4, bout = (d < bin).
// Gate-level, the subtracting twin of the lab's 2-bit adder cell.
module digit_sub
    import quad_down_counter_pkg::*;
(
    input  digit_t d,
    input  logic   bin,
    output digit_t q,
    output logic   bout
);

    logic nd0;
    logic nd1;
    logic b1;

    not g_n0 (nd0, d[0]);
    not g_n1 (nd1, d[1]);

    xor g_q0 (q[0], d[0], bin);
    and g_b1 (b1, nd0, bin);

    xor g_q1 (q[1], d[1], b1);
    and g_bo (bout, nd1, b1);

endmodule

// File: rtl/quad_down_counter.sv
// Loadable cascaded base-4 down counter with one-shot or periodic reload.
// Expiry is the chain's final borrow-out: only count==0 borrows past the top.
module quad_down_counter
    import quad_down_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PERIODIC = 0
) (
    input logic                clk,
    input logic                reset,
    quad_down_counter_if.slave bus
);

    localparam int W = DIGITS * DIGIT_W;

    state_t         state;
    logic [W-1:0]   cnt;
    logic [W-1:0]   reload;
    logic [W-1:0]   dec;
    logic [DIGITS:0] borrow;
    logic           expire_q;
    logic           busy_q;
    logic           hit;

    assign borrow[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        digit_sub u_sub (
            .d    (cnt[DIGIT_W*k +: DIGIT_W]),
            .bin  (borrow[k]),
            .q    (dec[DIGIT_W*k +: DIGIT_W]),
            .bout (borrow[k+1])
        );
    end

    assign hit = borrow[DIGITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            reload   <= '0;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.load) begin
            state    <= RUN;
            cnt      <= bus.load_val;
            reload   <= bus.load_val;
            expire_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            expire_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                end
                RUN: begin
                    if (bus.en) begin
                        if (hit) begin
                            expire_q <= 1'b1;
                            if (PERIODIC != 0) begin
                                cnt <= reload;
                            end else begin
                                state  <= EXPIRED;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            cnt <= dec;
                        end
                    end
                end
                EXPIRED: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count  = cnt;
    assign bus.zero   = (cnt == '0);
    assign bus.expire = expire_q;
    assign bus.busy   = busy_q;

endmodule
